// File: rtl/hs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hs_pkg
// Purpose : Shared definitions for the valid/ready stream source and the
//           sinks/checkers that sit next to it in the lab pipeline.
//           - FSM state encodings ST_IDLE / ST_RUN / ST_DRAIN
//           - clamp_len(): limits a requested beat count to the buffer depth
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package hs_pkg;

  localparam int STATE_W = 2;

  // IDLE : waiting for a start command
  // RUN  : launching beats from the buffer
  // DRAIN: no more beats will be launched; waiting for the pending beat to fire
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
  localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;

  // A pass can never be longer than the buffer, so oversize requests are
  // clipped to the depth rather than wrapping the index past the last word.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hs_src_mem.sv
`default_nettype none
// ============================================================================
// Module  : hs_src_mem
// Purpose : DEPTH x DATA_WIDTH word buffer for the stream source.
//           One synchronous write port, one asynchronous read port.
//           A read of the address being written in the same cycle returns
//           the old word (the write only lands on the clock edge).
//           Contents are not reset.
// Ports   : clk      in  1           write clock
//           wr_en    in  1           write strobe
//           wr_addr  in  ADDR_WIDTH  write address
//           wr_data  in  DATA_WIDTH  write data
//           rd_addr  in  ADDR_WIDTH  read address
//           rd_data  out DATA_WIDTH  read data (combinational)
// Revision: 1.0  initial release
// ============================================================================
module hs_src_mem
  import hs_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/hs_stream_src.sv
`default_nettype none
// ============================================================================
// Module  : hs_stream_src
// Purpose : Parametrised valid/ready stream source. Streams a programmable
//           number of words from a loadable buffer, one-shot or looping,
//           with a LAST marker on the final beat of each pass. The output
//           is a registered master: once valid rises, valid/data/last hold
//           until the beat fires.
// Config  : HS_STREAM_SRC_THROTTLE_EN - adds input valid_gate; a new beat is
//           only launched while valid_gate=1 (a pending beat is never
//           withdrawn). Undefined: beats launch whenever possible.
// Ports   : clk        in  1            clock (posedge)
//           rst_n      in  1            asynchronous active-low reset
//           wr_en      in  1            buffer write strobe
//           wr_addr    in  ADDR_WIDTH   buffer write address
//           wr_data    in  DATA_WIDTH   buffer write data
//           start      in  1            start pulse (IDLE only)
//           len        in  ADDR_WIDTH+1 beats per pass (sampled with start)
//           loop       in  1            wrap to word 0 after last beat
//           abort      in  1            stop at the next beat boundary
//           ready      in  1            downstream ready
//           valid_gate in  1            launch enable (throttle build only)
//           valid      out 1            beat valid
//           data       out DATA_WIDTH   beat payload
//           last       out 1            final beat of the pass
//           busy       out 1            state != IDLE
//           done       out 1            one-cycle end-of-stream pulse
// Revision: 1.0  initial release
// ============================================================================
module hs_stream_src
  import hs_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  loop,
  input  logic                  abort,
  input  logic                  ready,
`ifdef HS_STREAM_SRC_THROTTLE_EN
  input  logic                  valid_gate,
`endif
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last,
  output logic                  busy,
  output logic                  done
);

  localparam int LEN_W = ADDR_WIDTH + 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [STATE_W-1:0]    state_d, state_q;
  logic [LEN_W-1:0]      len_d,   len_q;
  logic                  loop_d,  loop_q;
  logic [ADDR_WIDTH-1:0] idx_d,   idx_q;
  logic                  valid_d, valid_q;
  logic [DATA_WIDTH-1:0] data_d,  data_q;
  logic                  last_d,  last_q;
  logic                  done_d,  done_q;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                  w_fire;
  logic                  w_gate;
  logic [LEN_W-1:0]      w_len_clamped;
  logic [ADDR_WIDTH-1:0] w_idx_sel;
  logic [LEN_W-1:0]      w_len_sel;
  logic                  w_loop_sel;
  logic                  w_beat_last;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_fire = valid_q & ready;

`ifdef HS_STREAM_SRC_THROTTLE_EN
  assign w_gate = valid_gate;
`else
  assign w_gate = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Buffer
  // --------------------------------------------------------------------------
  hs_src_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (w_idx_sel),
    .rd_data (w_rd_data)
  );

  // --------------------------------------------------------------------------
  // Load source selection. In IDLE the first beat is launched straight from
  // the incoming command so valid rises the cycle after start; afterwards the
  // registered pass parameters are used. Kept apart from the next-state block
  // so the buffer read path does not form a loop through one process.
  // --------------------------------------------------------------------------
  always_comb begin
    w_len_clamped = LEN_W'(clamp_len(32'(len), DEPTH));
    if (state_q == ST_IDLE) begin
      w_idx_sel  = '0;
      w_len_sel  = w_len_clamped;
      w_loop_sel = loop;
    end else begin
      w_idx_sel  = idx_q;
      w_len_sel  = len_q;
      w_loop_sel = loop_q;
    end
    w_beat_last = ({1'b0, w_idx_sel} == (w_len_sel - LEN_W'(1)));
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    loop_d  = loop_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = 1'b0;
    w_load  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Zero-length start is ignored; abort has no meaning here.
        if (start && (len != '0)) begin
          state_d = ST_RUN;
          len_d   = w_len_clamped;
          loop_d  = loop;
          idx_d   = '0;
          w_load  = w_gate;
        end
      end

      ST_RUN: begin
        if (abort) begin
          if (!valid_q || w_fire) begin
            // Nothing pending (or it completes now): finish immediately.
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            // Abort is a pulse; remember it by parking in DRAIN until the
            // pending beat is accepted.
            state_d = ST_DRAIN;
          end
        end else if (!valid_q || w_fire) begin
          if (w_gate) begin
            w_load = 1'b1;
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        if (w_fire) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Launch a beat into the output register. The index wraps at the pass
    // length; a one-shot pass stops launching after its final word.
    if (w_load) begin
      valid_d = 1'b1;
      data_d  = w_rd_data;
      last_d  = w_beat_last;
      if (w_beat_last) begin
        idx_d = '0;
        if (!w_loop_sel) begin
          state_d = ST_DRAIN;
        end
      end else begin
        idx_d = w_idx_sel + ADDR_WIDTH'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      loop_q  <= 1'b0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign valid = valid_q;
  assign data  = data_q;
  assign last  = last_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;

endmodule
`default_nettype wire
